// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared FSM encoding, segment constants and nibble decode
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Active-low gfedcba for a common-anode module
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/cnt_fnd_drv_if.sv
// rtl/cnt_fnd_drv_if.sv - count input and FND drive outputs of the display driver
interface cnt_fnd_drv_if #(
  parameter int BW_CNT = 4,
  parameter int NDIG   = 2
);
  logic [BW_CNT-1:0] i_cnt;
  logic [6:0]        o_seg;
  logic [NDIG-1:0]   o_com;
  logic              o_busy;

  modport master (output i_cnt, input  o_seg, o_com, o_busy);
  modport slave  (input  i_cnt, output o_seg, o_com, o_busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, restarts whenever the count changes
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int BW_CNT = 4,
  parameter int NDIG   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [BW_CNT-1:0]   cnt_i,
  output logic [4*NDIG-1:0]   bcd_o,
  output logic                done_o,
  output logic                busy_o
);
  localparam int BW_BCD = 4 * NDIG;
  localparam int CW     = $clog2(BW_CNT + 1);

  state_e              state_q, state_d;
  logic [BW_CNT-1:0]   last_q, last_d;
  logic [BW_CNT-1:0]   shreg_q, shreg_d;
  logic [BW_BCD-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_q   <= '0;
      shreg_q  <= '0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < NDIG; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (cnt_i != last_q) begin
          last_d   = cnt_i;
          shreg_d  = cnt_i;
          bcd_d    = '0;
          bitcnt_d = CW'(BW_CNT);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The top BCD bit falls off, so the result wraps at 10^NDIG
        {bcd_d, shreg_d} = {bcd_adj[BW_BCD-2:0], shreg_q, 1'b0};
        bitcnt_d = bitcnt_q - CW'(1);
        if (bitcnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd_o  = bcd_q;
  assign done_o = (state_q == DONE);
  assign busy_o = busy_q;

endmodule

// File: rtl/cnt_fnd_drv.sv
// rtl/cnt_fnd_drv.sv - counter-to-FND driver: BCD conversion plus multiplexed digit scan
module cnt_fnd_drv
  import fnd_pkg::*;
#(
  parameter int BW_CNT  = 4,
  parameter int NDIG    = 2,
  parameter int SCANDIV = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  cnt_fnd_drv_if.slave  bus
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int RW = (SCANDIV > 1) ? $clog2(SCANDIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(SCANDIV - 1);

  logic [4*NDIG-1:0] bcd;
  logic              conv_done;
  logic              conv_busy;

  logic [4*NDIG-1:0] dig_q, dig_d;
  logic [RW-1:0]     ref_q, ref_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [NDIG-1:0]   com_q, com_d;

  bin2bcd_seq #(
    .BW_CNT (BW_CNT),
    .NDIG   (NDIG)
  ) u_conv (
    .clk_i  (i_clk),
    .rst_ni (i_rstn),
    .cnt_i  (bus.i_cnt),
    .bcd_o  (bcd),
    .done_o (conv_done),
    .busy_o (conv_busy)
  );

  // idx resets to the last digit so the first scan slot lands on digit 0
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dig_q <= '0;
      ref_q <= '0;
      idx_q <= IDX_LAST;
      seg_q <= SEG_BLANK;
      com_q <= '1;
    end else begin
      dig_q <= dig_d;
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      com_q <= com_d;
    end
  end

  always_comb begin
    dig_d = conv_done ? bcd : dig_q;
    ref_d = ref_q + RW'(1);
    idx_d = idx_q;
    seg_d = seg_q;
    com_d = com_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      com_d = ~(NDIG'(1) << idx_d);
      seg_d = seg_decode(dig_q[4*int'(idx_d) +: 4]);
    end
  end

  assign bus.o_seg  = seg_q;
  assign bus.o_com  = com_q;
  assign bus.o_busy = conv_busy;

endmodule
